// File: rtl/ac_sched_defs_pkg.sv
// Purpose: shared encodings, timing constants and slot windows for the aircon sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ac_sched_defs;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PRECOOL  = 3'd1,
    ST_COOLING  = 3'd2,
    ST_GRACE    = 3'd3,
    ST_OVERRIDE = 3'd4
  } ac_state_t;

  localparam logic [10:0] PRECOOL_MIN  = 11'd10;
  localparam logic [2:0]  GRACE_MIN    = 3'd5;
  localparam logic [4:0]  EMPTY_MIN    = 5'd15;
  localparam logic [4:0]  OVERRIDE_MIN = 5'd30;
  localparam logic [6:0]  MIN_TEMP     = 7'd18;
  localparam logic [6:0]  MAX_TEMP     = 7'd28;
  localparam logic [6:0]  PRECOOL_TEMP = 7'd24;

  localparam logic [2:0] DAY_MON = 3'd0;
  localparam logic [2:0] DAY_TUE = 3'd1;
  localparam logic [2:0] DAY_WED = 3'd2;
  localparam logic [2:0] DAY_THU = 3'd3;
  localparam logic [2:0] DAY_FRI = 3'd4;

  // Slot windows as minute-of-day, end exclusive.
  localparam logic [10:0] MTWT_S0 = 11'd460;
  localparam logic [10:0] MTWT_E0 = 11'd550;
  localparam logic [10:0] MTWT_S1 = 11'd560;
  localparam logic [10:0] MTWT_E1 = 11'd650;
  localparam logic [10:0] FRI_S0  = 11'd540;
  localparam logic [10:0] FRI_E0  = 11'd720;
  localparam logic [10:0] FRI_S1  = 11'd840;
  localparam logic [10:0] FRI_E1  = 11'd1020;

  localparam logic [1:0] SLOT_NONE = 2'd3;

  function automatic logic [6:0] clamp_temp(input logic [6:0] t);
    if (t < MIN_TEMP)      return MIN_TEMP;
    else if (t > MAX_TEMP) return MAX_TEMP;
    else                   return t;
  endfunction

  function automatic logic [6:0] grace_temp(input logic [6:0] clamped);
    if (clamped + 7'd2 > MAX_TEMP) return MAX_TEMP;
    else                           return clamped + 7'd2;
  endfunction

endpackage

// File: rtl/ac_slot_lookup.sv
// Purpose: map day count and time of day to slot membership and active/next slot index.
// Latency: combinational.
// Backpressure: none.
module ac_slot_lookup
  import ac_sched_defs::*;
(
  input  logic [6:0] day,
  input  logic [6:0] hour,
  input  logic [6:0] minute,
  output logic       in_slot,
  output logic       pre_slot,
  output logic [1:0] slot_id
);

  logic [2:0]  dow;
  logic [10:0] mod;
  logic        valid;
  logic        has_slots;
  logic [10:0] s0, e0, s1, e1;

  assign dow   = 3'(day % 7'd7);
  assign mod   = 11'(hour) * 11'd60 + 11'(minute);
  assign valid = (hour < 7'd24) && (minute < 7'd60);

  always_comb begin
    has_slots = 1'b1;
    s0 = MTWT_S0;
    e0 = MTWT_E0;
    s1 = MTWT_S1;
    e1 = MTWT_E1;
    if (dow == DAY_FRI) begin
      s0 = FRI_S0;
      e0 = FRI_E0;
      s1 = FRI_S1;
      e1 = FRI_E1;
    end else if (dow > DAY_FRI) begin
      has_slots = 1'b0;
    end
  end

  always_comb begin
    in_slot  = 1'b0;
    pre_slot = 1'b0;
    slot_id  = SLOT_NONE;
    if (valid && has_slots) begin
      in_slot  = ((mod >= s0) && (mod < e0)) || ((mod >= s1) && (mod < e1));
      pre_slot = ((mod >= s0 - PRECOOL_MIN) && (mod < s0)) ||
                 ((mod >= s1 - PRECOOL_MIN) && (mod < s1));
      // Before the end of slot 0 it is the active or upcoming slot, then slot 1.
      if (mod < e0)      slot_id = 2'd0;
      else if (mod < e1) slot_id = 2'd1;
    end
  end

endmodule

// File: rtl/ac_schedule_ctrl.sv
// Purpose: classroom aircon sequencer; slot-driven FSM with precool, empty-room grace and manual override.
// Latency: 1 clock from any input change to registered outputs.
// Backpressure: none; inputs sampled every cycle, counters advance only on MinuteTick.
module ac_schedule_ctrl
  import ac_sched_defs::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       MinuteTick,
  input  logic [6:0] DayCombine,
  input  logic [6:0] HourCombine,
  input  logic [6:0] MinuteCombine,
  input  logic [6:0] Occupants,
  input  logic [6:0] OptTemp,
  input  logic       OverrideReq,
  output logic       AcOn,
  output logic [6:0] Setpoint,
  output logic [2:0] State,
  output logic [1:0] SlotId
);

  ac_state_t  state_q, state_d;
  logic [4:0] empty_q, empty_d, empty_run;
  logic [2:0] grace_q, grace_d, grace_run;
  logic [4:0] ovr_q, ovr_d, ovr_run;
  logic       in_slot, pre_slot;
  logic [1:0] slot_id;
  logic       occupied;
  logic       ac_d;
  logic [6:0] sp_d;
  logic [6:0] clamped;

  ac_slot_lookup u_lookup (
    .day     (DayCombine),
    .hour    (HourCombine),
    .minute  (MinuteCombine),
    .in_slot (in_slot),
    .pre_slot(pre_slot),
    .slot_id (slot_id)
  );

  assign occupied = (Occupants != 7'd0);
  assign clamped  = clamp_temp(OptTemp);
  assign State    = state_q;

  // Counter values after this cycle's tick; decisions use these so expiry lands on the tick itself.
  always_comb begin
    empty_run = empty_q;
    if (state_q != ST_COOLING || occupied)    empty_run = 5'd0;
    else if (MinuteTick && empty_q != 5'h1f)  empty_run = empty_q + 5'd1;
    grace_run = grace_q;
    if (MinuteTick && grace_q != 3'd0)        grace_run = grace_q - 3'd1;
    ovr_run = ovr_q;
    if (MinuteTick && ovr_q != 5'd0)          ovr_run = ovr_q - 5'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (OverrideReq)   state_d = ST_OVERRIDE;
        else if (in_slot)  state_d = ST_COOLING;
        else if (pre_slot) state_d = ST_PRECOOL;
      end
      ST_PRECOOL: begin
        if (OverrideReq)    state_d = ST_OVERRIDE;
        else if (in_slot)   state_d = ST_COOLING;
        else if (!pre_slot) state_d = ST_OFF;
      end
      ST_COOLING: begin
        if (!in_slot || empty_run >= EMPTY_MIN) state_d = ST_GRACE;
      end
      ST_GRACE: begin
        if (OverrideReq)               state_d = ST_OVERRIDE;
        else if (in_slot && occupied)  state_d = ST_COOLING;
        else if (grace_run == 3'd0)    state_d = ST_OFF;
      end
      ST_OVERRIDE: begin
        if (OverrideReq || ovr_run == 5'd0) state_d = in_slot ? ST_COOLING : ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    // Entering a state loads its counter; staying keeps the ticked value; elsewhere it rests at zero.
    empty_d = (state_d == ST_COOLING && state_q == ST_COOLING) ? empty_run : 5'd0;
    grace_d = (state_d == ST_GRACE) ? ((state_q == ST_GRACE) ? grace_run : GRACE_MIN) : 3'd0;
    ovr_d   = (state_d == ST_OVERRIDE) ? ((state_q == ST_OVERRIDE) ? ovr_run : OVERRIDE_MIN) : 5'd0;
  end

  always_comb begin
    ac_d = (state_d != ST_OFF);
    case (state_d)
      ST_COOLING, ST_OVERRIDE: sp_d = clamped;
      ST_PRECOOL:              sp_d = PRECOOL_TEMP;
      ST_GRACE:                sp_d = grace_temp(clamped);
      default:                 sp_d = 7'd0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_OFF;
      empty_q  <= 5'd0;
      grace_q  <= 3'd0;
      ovr_q    <= 5'd0;
      AcOn     <= 1'b0;
      Setpoint <= 7'd0;
      SlotId   <= SLOT_NONE;
    end else begin
      state_q  <= state_d;
      empty_q  <= empty_d;
      grace_q  <= grace_d;
      ovr_q    <= ovr_d;
      AcOn     <= ac_d;
      Setpoint <= sp_d;
      SlotId   <= slot_id;
    end
  end

endmodule

// File: tb/tb_ac_schedule_ctrl.sv
// Directed scenarios for the aircon sequencer; expectations queued by stimulus, compared by a monitor.
module tb_ac_schedule_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       MinuteTick;
  logic [6:0] DayCombine, HourCombine, MinuteCombine, Occupants, OptTemp;
  logic       OverrideReq;
  logic       AcOn;
  logic [6:0] Setpoint;
  logic [2:0] State;
  logic [1:0] SlotId;

  typedef struct packed {
    logic [2:0] st;
    logic       ac;
    logic [6:0] sp;
    logic [1:0] sid;
  } out_t;

  out_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    hr, mn;

  ac_schedule_ctrl dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .MinuteTick   (MinuteTick),
    .DayCombine   (DayCombine),
    .HourCombine  (HourCombine),
    .MinuteCombine(MinuteCombine),
    .Occupants    (Occupants),
    .OptTemp      (OptTemp),
    .OverrideReq  (OverrideReq),
    .AcOn         (AcOn),
    .Setpoint     (Setpoint),
    .State        (State),
    .SlotId       (SlotId)
  );

  always #5 Clock = ~Clock;

  // Monitor: compares every queued expectation against the outputs on the falling edge.
  always @(negedge Clock) begin
    out_t  e;
    out_t  got;
    string t;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = '{st: State, ac: AcOn, sp: Setpoint, sid: SlotId};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got state=%0d acon=%0d setpoint=%0d slot=%0d, expected state=%0d acon=%0d setpoint=%0d slot=%0d",
                 t, got.st, got.ac, got.sp, got.sid, e.st, e.ac, e.sp, e.sid);
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st, input logic ac,
                            input logic [6:0] sp, input logic [1:0] sid);
    exp_q.push_back('{st: st, ac: ac, sp: sp, sid: sid});
    tag_q.push_back(tag);
  endtask

  task automatic set_time(input int d, input int h, input int m);
    hr = h;
    mn = m;
    DayCombine    = 7'(d);
    HourCombine   = 7'(h);
    MinuteCombine = 7'(m);
  endtask

  task automatic tick();
    mn++;
    if (mn == 60) begin
      mn = 0;
      hr++;
    end
    HourCombine   = 7'(hr);
    MinuteCombine = 7'(mn);
    MinuteTick    = 1'b1;
    step();
    MinuteTick    = 1'b0;
  endtask

  task automatic tick_ovr();
    OverrideReq = 1'b1;
    tick();
    OverrideReq = 1'b0;
  endtask

  task automatic ovr_pulse();
    OverrideReq = 1'b1;
    step();
    OverrideReq = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; MinuteTick = 1'b0; OverrideReq = 1'b0;
    Occupants = 7'd0; OptTemp = 7'd22;
    set_time(5, 0, 0);
    repeat (3) step();
    expect_out("reset_state", 3'd0, 1'b0, 7'd0, 2'd3);
    Reset = 1'b0;
    step();
    expect_out("idle_weekend", 3'd0, 1'b0, 7'd0, 2'd3);

    // Monday precool then cooling
    set_time(0, 7, 29); Occupants = 7'd10; OptTemp = 7'd22;
    step();
    expect_out("mon_0729_off", 3'd0, 1'b0, 7'd0, 2'd0);
    tick();
    expect_out("mon_0730_precool", 3'd1, 1'b1, 7'd24, 2'd0);
    repeat (9) tick();
    expect_out("mon_0739_precool", 3'd1, 1'b1, 7'd24, 2'd0);
    tick();
    expect_out("mon_0740_cooling", 3'd2, 1'b1, 7'd22, 2'd0);

    // Reset mid-cooling, held three cycles
    Reset = 1'b1;
    step();
    expect_out("reset_mid_cool_1", 3'd0, 1'b0, 7'd0, 2'd3);
    step(); step();
    expect_out("reset_mid_cool_3", 3'd0, 1'b0, 7'd0, 2'd3);
    Reset = 1'b0;
    step();
    expect_out("post_reset_cooling", 3'd2, 1'b1, 7'd22, 2'd0);

    // Tuesday slot end, grace countdown, precool gap, next slot
    set_time(1, 9, 9);
    step();
    expect_out("tue_0909_cooling", 3'd2, 1'b1, 7'd22, 2'd0);
    tick();
    expect_out("tue_0910_grace", 3'd3, 1'b1, 7'd24, 2'd1);
    repeat (4) tick();
    expect_out("tue_0914_grace", 3'd3, 1'b1, 7'd24, 2'd1);
    tick();
    expect_out("tue_0915_off", 3'd0, 1'b0, 7'd0, 2'd1);
    step();
    expect_out("tue_0915_precool", 3'd1, 1'b1, 7'd24, 2'd1);
    repeat (4) tick();
    tick();
    expect_out("tue_0920_cooling", 3'd2, 1'b1, 7'd22, 2'd1);

    // Friday empty room
    set_time(4, 10, 0); Occupants = 7'd0;
    step();
    expect_out("fri_1000_cooling", 3'd2, 1'b1, 7'd22, 2'd0);
    repeat (14) tick();
    expect_out("fri_empty_14", 3'd2, 1'b1, 7'd22, 2'd0);
    tick();
    expect_out("fri_empty_15_grace", 3'd3, 1'b1, 7'd24, 2'd0);
    tick();
    expect_out("fri_grace_tick1", 3'd3, 1'b1, 7'd24, 2'd0);
    Occupants = 7'd5;
    tick();
    expect_out("fri_reoccupied", 3'd2, 1'b1, 7'd22, 2'd0);

    // Saturday: grace with hot OptTemp, then override runs
    set_time(5, 10, 20); Occupants = 7'd0; OptTemp = 7'd35;
    step();
    expect_out("sat_grace_cap", 3'd3, 1'b1, 7'd28, 2'd3);
    repeat (4) tick();
    expect_out("sat_grace_4", 3'd3, 1'b1, 7'd28, 2'd3);
    tick();
    expect_out("sat_grace_off", 3'd0, 1'b0, 7'd0, 2'd3);
    ovr_pulse();
    expect_out("sat_override", 3'd4, 1'b1, 7'd28, 2'd3);
    repeat (29) tick();
    expect_out("sat_override_29", 3'd4, 1'b1, 7'd28, 2'd3);
    tick();
    expect_out("sat_override_expire", 3'd0, 1'b0, 7'd0, 2'd3);
    ovr_pulse();
    expect_out("sat_override2", 3'd4, 1'b1, 7'd28, 2'd3);
    repeat (9) tick();
    expect_out("sat_override2_9", 3'd4, 1'b1, 7'd28, 2'd3);
    tick_ovr();
    expect_out("sat_override_cancel", 3'd0, 1'b0, 7'd0, 2'd3);

    // Override and tick together; cold OptTemp
    OptTemp = 7'd10;
    tick_ovr();
    expect_out("ovr_tick_same_cycle", 3'd4, 1'b1, 7'd18, 2'd3);
    repeat (29) tick();
    expect_out("ovr_tick_29", 3'd4, 1'b1, 7'd18, 2'd3);
    tick();
    expect_out("ovr_tick_30_off", 3'd0, 1'b0, 7'd0, 2'd3);

    // Override inside a slot returns to cooling; invalid hour drops the slot
    set_time(0, 8, 0); Occupants = 7'd10; OptTemp = 7'd22;
    ovr_pulse();
    expect_out("mon_override_in_slot", 3'd4, 1'b1, 7'd22, 2'd0);
    ovr_pulse();
    expect_out("mon_override_to_cool", 3'd2, 1'b1, 7'd22, 2'd0);
    HourCombine = 7'd30;
    step();
    expect_out("bad_hour_grace", 3'd3, 1'b1, 7'd24, 2'd3);

    step(); step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
